// File: rtl/msrv32_pkg.sv
// Shared fetch-stage definitions: AHB transfer encodings and instruction buffer entry layout.
package msrv32_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_NONSEQ = 2'b10
   } htrans_e;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned PC_W    = 32;
   localparam int unsigned ENTRY_W = INSTR_W + PC_W + 1;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
      logic               fault;
   } fetch_entry_t;

endpackage

// File: rtl/msrv32_ifetch_fifo.sv
// Generic synchronous FIFO with flush; a push coincident with flush lands as the sole entry.
module msrv32_ifetch_fifo #(
   parameter int unsigned WIDTH = 65,
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         head_data,
   output logic                     head_valid,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             pop_en;

   assign head_valid = (count != '0);
   assign head_data  = head_valid ? mem[rd_ptr] : '0;
   assign pop_en     = pop & head_valid & ~flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= push ? PTR_W'(1) : '0;
         count  <= push ? ($clog2(DEPTH)+1)'(1) : '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop_en)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[flush ? '0 : wr_ptr] <= push_data;
   end

endmodule

// File: rtl/msrv32_ifetch.sv
// Instruction fetch: owns the PC, issues single-beat AHB-Lite reads and buffers results for decode.
module msrv32_ifetch
   import msrv32_pkg::*;
#(
   parameter logic [31:0]  BOOT_ADDRESS = 32'h0000_0000,
   parameter int unsigned  FIFO_DEPTH   = 2
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic [31:0] pc_mux_in,
   input  logic        redirect_in,
   input  logic        misaligned_instr_in,
   output logic [31:0] pc_out,
   output logic        ahb_ready_out,
   output logic [31:0] haddr_out,
   output logic [1:0]  htrans_out,
   input  logic        hready_in,
   input  logic [31:0] hrdata_in,
   input  logic        hresp_in,
   output logic        instr_valid_out,
   output logic [31:0] instr_out,
   output logic [31:0] instr_pc_out,
   output logic        instr_fault_out,
   input  logic        instr_ready_in
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]      pc_q, tag_pc_q, pend_pc_q;
   logic             outstanding_q, discard_q, halted_q, pend_q, rst_exit_q;
   logic [31:0]      pc_d, tag_pc_d, pend_pc_d;
   logic             outstanding_d, discard_d, halted_d, pend_d;

   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W-1:0] inflight;
   logic             credit_ok, nonseq, accept, complete, fault_now;
   logic             push, pop;
   fetch_entry_t     push_entry, head_entry;
   logic             head_valid;

   assign inflight  = fifo_count + CNT_W'(outstanding_q);
   assign credit_ok = inflight < CNT_W'(FIFO_DEPTH);
   assign nonseq    = ~halted_q & ~rst_exit_q & credit_ok;
   assign accept    = nonseq & hready_in;
   assign complete  = outstanding_q & hready_in;
   assign fault_now = complete & ~discard_q & ~redirect_in & hresp_in;
   assign pop       = head_valid & instr_ready_in;

   assign pc_out        = pc_q;
   assign haddr_out     = pc_q;
   assign htrans_out    = nonseq ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign ahb_ready_out = accept;

   always_comb begin
      pc_d          = pc_q;
      tag_pc_d      = tag_pc_q;
      pend_pc_d     = pend_pc_q;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;
      halted_d      = halted_q;
      pend_d        = pend_q;
      push          = 1'b0;
      push_entry    = '0;

      if (complete) begin
         outstanding_d = 1'b0;
         discard_d     = 1'b0;
         if (!discard_q && !redirect_in) begin
            push             = 1'b1;
            push_entry.instr = hresp_in ? '0 : hrdata_in;
            push_entry.pc    = tag_pc_q;
            push_entry.fault = hresp_in;
            if (hresp_in)
               halted_d = 1'b1;
         end
      end

      // A beat accepted alongside a fault completion, or after a deferred redirect, is stale.
      if (accept) begin
         outstanding_d = 1'b1;
         tag_pc_d      = pc_q;
         discard_d     = pend_q | fault_now;
         pc_d          = pend_q ? pend_pc_q : pc_mux_in;
         pend_d        = 1'b0;
      end

      if (redirect_in) begin
         halted_d = 1'b0;
         if (outstanding_d)
            discard_d = 1'b1;
         if (misaligned_instr_in) begin
            pc_d             = pc_mux_in;
            pend_d           = 1'b0;
            push             = 1'b1;
            push_entry.instr = '0;
            push_entry.pc    = pc_mux_in;
            push_entry.fault = 1'b1;
            halted_d         = 1'b1;
         end else if (nonseq && !hready_in) begin
            pend_d    = 1'b1;
            pend_pc_d = pc_mux_in;
         end else begin
            pc_d   = pc_mux_in;
            pend_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         pc_q          <= BOOT_ADDRESS;
         tag_pc_q      <= '0;
         pend_pc_q     <= '0;
         outstanding_q <= 1'b0;
         discard_q     <= 1'b0;
         halted_q      <= 1'b0;
         pend_q        <= 1'b0;
         rst_exit_q    <= 1'b1;
      end else begin
         pc_q          <= pc_d;
         tag_pc_q      <= tag_pc_d;
         pend_pc_q     <= pend_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         halted_q      <= halted_d;
         pend_q        <= pend_d;
         rst_exit_q    <= 1'b0;
      end
   end

   msrv32_ifetch_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk_in),
      .rst_n      (rst_n_in),
      .push       (push),
      .push_data  (push_entry),
      .pop        (pop),
      .flush      (redirect_in),
      .head_data  (head_entry),
      .head_valid (head_valid),
      .count      (fifo_count)
   );

   assign instr_valid_out = head_valid;
   assign instr_out       = head_entry.instr;
   assign instr_pc_out    = head_entry.pc;
   assign instr_fault_out = head_entry.fault;

endmodule

// File: tb/tb_msrv32_ifetch.sv
// Directed table-driven bench for msrv32_ifetch with a zero-latency AHB slave and a simple next-PC model.
module tb_msrv32_ifetch;

   logic        clk;
   logic        rst_n;
   logic [31:0] pc_mux;
   logic        redirect;
   logic        misaligned;
   logic [31:0] target;
   logic [31:0] pc_out;
   logic        ahb_ready;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hready;
   logic [31:0] hrdata;
   logic        hresp;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_fault;
   logic        instr_ready;

   int n_cmp = 0;
   int n_err = 0;

   logic        dph_valid;
   logic [31:0] dph_addr;

   typedef struct {
      logic        hr, ir, rd, mis, hresp;
      logic [31:0] tgt;
      logic        ht;
      logic [31:0] addr;
      logic        ar, v;
      logic [31:0] ipc;
      logic        flt;
   } vec_t;

   vec_t vecs[$];

   msrv32_ifetch #(
      .BOOT_ADDRESS (32'h0000_0000),
      .FIFO_DEPTH   (2)
   ) dut (
      .clk_in              (clk),
      .rst_n_in            (rst_n),
      .pc_mux_in           (pc_mux),
      .redirect_in         (redirect),
      .misaligned_instr_in (misaligned),
      .pc_out              (pc_out),
      .ahb_ready_out       (ahb_ready),
      .haddr_out           (haddr),
      .htrans_out          (htrans),
      .hready_in           (hready),
      .hrdata_in           (hrdata),
      .hresp_in            (hresp),
      .instr_valid_out     (instr_valid),
      .instr_out           (instr),
      .instr_pc_out        (instr_pc),
      .instr_fault_out     (instr_fault),
      .instr_ready_in      (instr_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   // Next-PC source: sequential +4 unless the bench requests a redirect.
   assign pc_mux = redirect ? target : pc_out + 32'd4;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dph_valid <= 1'b0;
         dph_addr  <= '0;
      end else if (hready) begin
         dph_valid <= (htrans == 2'b10);
         dph_addr  <= haddr;
      end
   end

   assign hrdata = dph_valid ? mem_word(dph_addr) : 32'hDEAD_BEEF;

   function automatic vec_t mk(input logic hr, input logic ir, input logic rd, input logic mis,
                               input logic hrs, input logic [31:0] tgt, input logic ht,
                               input logic [31:0] addr, input logic ar, input logic v,
                               input logic [31:0] ipc, input logic flt);
      vec_t r;
      r.hr = hr; r.ir = ir; r.rd = rd; r.mis = mis; r.hresp = hrs; r.tgt = tgt;
      r.ht = ht; r.addr = addr; r.ar = ar; r.v = v; r.ipc = ipc; r.flt = flt;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic ht, input logic [31:0] addr,
                             input logic ar, input logic v, input logic [31:0] ipc,
                             input logic flt);
      logic [31:0] exp_instr;
      exp_instr = (v && !flt) ? mem_word(ipc) : 32'h0;
      chk({tag, ".htrans"}, 32'(htrans), ht ? 32'h2 : 32'h0);
      chk({tag, ".haddr"},  haddr, addr);
      chk({tag, ".pc_out"}, pc_out, addr);
      chk({tag, ".ahb_ready"}, 32'(ahb_ready), 32'(ar));
      chk({tag, ".valid"}, 32'(instr_valid), 32'(v));
      chk({tag, ".instr_pc"}, instr_pc, v ? ipc : 32'h0);
      chk({tag, ".fault"}, 32'(instr_fault), v ? 32'(flt) : 32'h0);
      chk({tag, ".instr"}, instr, exp_instr);
   endtask

   task automatic apply_vec(input vec_t t, input string tag);
      hready      = t.hr;
      instr_ready = t.ir;
      redirect    = t.rd;
      misaligned  = t.mis;
      hresp       = t.hresp;
      target      = t.tgt;
      #1;
      check_outs(tag, t.ht, t.addr, t.ar, t.v, t.ipc, t.flt);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //                hr  ir  rd  mis hrs tgt           ht  addr          ar  v   ipc           flt
      // back-to-back fetch from boot
      vecs.push_back(mk(1,  1,  0,  0,  0,  32'h0,        0,  32'h0,        0,  0,  32'h0,        0));
      vecs.push_back(mk(1,  1,  0,  0,  0,  32'h0,        1,  32'h0,        1,  0,  32'h0,        0));
      vecs.push_back(mk(1,  1,  0,  0,  0,  32'h0,        1,  32'h4,        1,  0,  32'h0,        0));
      vecs.push_back(mk(1,  1,  0,  0,  0,  32'h0,        0,  32'h8,        0,  1,  32'h0,        0));
      vecs.push_back(mk(1,  1,  0,  0,  0,  32'h0,        1,  32'h8,        1,  1,  32'h4,        0));
      vecs.push_back(mk(1,  1,  0,  0,  0,  32'h0,        1,  32'hC,        1,  0,  32'h0,        0));
      vecs.push_back(mk(1,  1,  0,  0,  0,  32'h0,        0,  32'h10,       0,  1,  32'h8,        0));
      vecs.push_back(mk(1,  1,  0,  0,  0,  32'h0,        1,  32'h10,       1,  1,  32'hC,        0));
      // two wait states on beat 0x10 while 0x14 is presented
      vecs.push_back(mk(0,  1,  0,  0,  0,  32'h0,        1,  32'h14,       0,  0,  32'h0,        0));
      vecs.push_back(mk(0,  1,  0,  0,  0,  32'h0,        1,  32'h14,       0,  0,  32'h0,        0));
      vecs.push_back(mk(1,  1,  0,  0,  0,  32'h0,        1,  32'h14,       1,  0,  32'h0,        0));
      vecs.push_back(mk(1,  1,  0,  0,  0,  32'h0,        0,  32'h18,       0,  1,  32'h10,       0));
      vecs.push_back(mk(1,  1,  0,  0,  0,  32'h0,        1,  32'h18,       1,  1,  32'h14,       0));
      // decode stall: FIFO fills to two, bus idles
      vecs.push_back(mk(1,  0,  0,  0,  0,  32'h0,        1,  32'h1C,       1,  0,  32'h0,        0));
      vecs.push_back(mk(1,  0,  0,  0,  0,  32'h0,        0,  32'h20,       0,  1,  32'h18,       0));
      vecs.push_back(mk(1,  0,  0,  0,  0,  32'h0,        0,  32'h20,       0,  1,  32'h18,       0));
      vecs.push_back(mk(1,  0,  0,  0,  0,  32'h0,        0,  32'h20,       0,  1,  32'h18,       0));
      vecs.push_back(mk(1,  0,  0,  0,  0,  32'h0,        0,  32'h20,       0,  1,  32'h18,       0));
      vecs.push_back(mk(1,  1,  0,  0,  0,  32'h0,        0,  32'h20,       0,  1,  32'h18,       0));
      vecs.push_back(mk(1,  1,  0,  0,  0,  32'h0,        1,  32'h20,       1,  1,  32'h1C,       0));
      vecs.push_back(mk(1,  1,  0,  0,  0,  32'h0,        1,  32'h24,       1,  0,  32'h0,        0));
      vecs.push_back(mk(1,  0,  0,  0,  0,  32'h0,        0,  32'h28,       0,  1,  32'h20,       0));
      vecs.push_back(mk(1,  1,  0,  0,  0,  32'h0,        0,  32'h28,       0,  1,  32'h20,       0));
      vecs.push_back(mk(1,  0,  0,  0,  0,  32'h0,        1,  32'h28,       1,  1,  32'h24,       0));
      // redirect to 0x100 with 0x24 buffered and 0x28 in a wait state
      vecs.push_back(mk(0,  1,  1,  0,  0,  32'h100,      0,  32'h2C,       0,  1,  32'h24,       0));
      vecs.push_back(mk(1,  1,  0,  0,  0,  32'h0,        1,  32'h100,      1,  0,  32'h0,        0));
      vecs.push_back(mk(1,  1,  0,  0,  0,  32'h0,        1,  32'h104,      1,  0,  32'h0,        0));
      vecs.push_back(mk(1,  1,  0,  0,  0,  32'h0,        0,  32'h108,      0,  1,  32'h100,      0));
      vecs.push_back(mk(1,  1,  0,  0,  0,  32'h0,        1,  32'h108,      1,  1,  32'h104,      0));
      // bus error on 0x108 halts fetch until redirect to 0x200
      vecs.push_back(mk(1,  0,  0,  0,  1,  32'h0,        1,  32'h10C,      1,  0,  32'h0,        0));
      vecs.push_back(mk(1,  0,  0,  0,  0,  32'h0,        0,  32'h110,      0,  1,  32'h108,      1));
      vecs.push_back(mk(1,  0,  0,  0,  0,  32'h0,        0,  32'h110,      0,  1,  32'h108,      1));
      vecs.push_back(mk(1,  1,  0,  0,  0,  32'h0,        0,  32'h110,      0,  1,  32'h108,      1));
      vecs.push_back(mk(1,  1,  0,  0,  0,  32'h0,        0,  32'h110,      0,  0,  32'h0,        0));
      vecs.push_back(mk(1,  1,  1,  0,  0,  32'h200,      0,  32'h110,      0,  0,  32'h0,        0));
      vecs.push_back(mk(1,  1,  0,  0,  0,  32'h0,        1,  32'h200,      1,  0,  32'h0,        0));
      vecs.push_back(mk(1,  1,  0,  0,  0,  32'h0,        1,  32'h204,      1,  0,  32'h0,        0));
      vecs.push_back(mk(1,  1,  0,  0,  0,  32'h0,        0,  32'h208,      0,  1,  32'h200,      0));
      // misaligned redirect to 0x102: one fault entry, no fetch at target
      vecs.push_back(mk(1,  1,  1,  1,  0,  32'h102,      1,  32'h208,      1,  1,  32'h204,      0));
      vecs.push_back(mk(1,  0,  0,  0,  0,  32'h0,        0,  32'h102,      0,  1,  32'h102,      1));
      vecs.push_back(mk(1,  0,  0,  0,  0,  32'h0,        0,  32'h102,      0,  1,  32'h102,      1));
      vecs.push_back(mk(1,  1,  0,  0,  0,  32'h0,        0,  32'h102,      0,  1,  32'h102,      1));
      vecs.push_back(mk(1,  1,  0,  0,  0,  32'h0,        0,  32'h102,      0,  0,  32'h0,        0));
      // redirect during a stalled address phase is deferred until accept
      vecs.push_back(mk(1,  1,  1,  0,  0,  32'h300,      0,  32'h102,      0,  0,  32'h0,        0));
      vecs.push_back(mk(0,  1,  0,  0,  0,  32'h0,        1,  32'h300,      0,  0,  32'h0,        0));
      vecs.push_back(mk(0,  1,  1,  0,  0,  32'h400,      1,  32'h300,      0,  0,  32'h0,        0));
      vecs.push_back(mk(0,  1,  0,  0,  0,  32'h0,        1,  32'h300,      0,  0,  32'h0,        0));
      vecs.push_back(mk(1,  1,  0,  0,  0,  32'h0,        1,  32'h300,      1,  0,  32'h0,        0));
      vecs.push_back(mk(1,  1,  0,  0,  0,  32'h0,        1,  32'h400,      1,  0,  32'h0,        0));
      vecs.push_back(mk(1,  1,  0,  0,  0,  32'h0,        1,  32'h404,      1,  0,  32'h0,        0));

      rst_n       = 1'b0;
      hready      = 1'b1;
      instr_ready = 1'b1;
      redirect    = 1'b0;
      misaligned  = 1'b0;
      hresp       = 1'b0;
      target      = '0;

      repeat (3) @(negedge clk);
      check_outs("reset", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

      @(negedge clk);
      rst_n = 1'b1;
      foreach (vecs[i]) begin
         apply_vec(vecs[i], $sformatf("v%0d", i));
         @(negedge clk);
      end

      // 0x400 buffered, 0x404 held in its data phase, then reset mid-transfer
      apply_vec(mk(0, 0, 0, 0, 0, 32'h0, 0, 32'h408, 0, 1, 32'h400, 0), "pre_rst");
      #2;
      rst_n  = 1'b0;
      hready = 1'b1;
      #1;
      check_outs("mid_rst", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      apply_vec(mk(1, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0), "rs0");
      @(negedge clk);
      apply_vec(mk(1, 1, 0, 0, 0, 32'h0, 1, 32'h0, 1, 0, 32'h0, 0), "rs1");
      @(negedge clk);
      apply_vec(mk(1, 1, 0, 0, 0, 32'h0, 1, 32'h4, 1, 0, 32'h0, 0), "rs2");
      @(negedge clk);
      apply_vec(mk(1, 1, 0, 0, 0, 32'h0, 0, 32'h8, 0, 1, 32'h0, 0), "rs3");
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
